// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/shift/arith-shift/rotate/load, with a
// saturating shift counter and a one-cycle done pulse when the count hits WIDTH.
module universal_shift_reg #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic [WIDTH-1:0]             d,
  input  logic                         sin_r,
  input  logic                         sin_l,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_l,
  output logic                         sout_r,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         done
);

  localparam int unsigned CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ASR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_LOAD = 3'b110;

  logic [WIDTH-1:0] q_nxt;
  logic             is_shift;
  logic             is_load;

  always_comb begin
    q_nxt    = q;
    is_shift = 1'b0;
    is_load  = 1'b0;
    case (mode)
      M_SHL:  begin q_nxt = {q[WIDTH-2:0], sin_r};    is_shift = 1'b1; end
      M_SHR:  begin q_nxt = {sin_l, q[WIDTH-1:1]};    is_shift = 1'b1; end
      M_ASR:  begin q_nxt = {q[WIDTH-1], q[WIDTH-1:1]}; is_shift = 1'b1; end
      M_ROL:  begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]}; is_shift = 1'b1; end
      M_ROR:  begin q_nxt = {q[0], q[WIDTH-1:1]};     is_shift = 1'b1; end
      M_LOAD: begin q_nxt = d;                        is_load  = 1'b1; end
      default: q_nxt = q; // hold and reserved encoding
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= RESET_VAL;
      cnt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      q <= q_nxt;
      if (is_load)
        cnt <= '0;
      else if (is_shift && cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
      // only the WIDTH-1 -> WIDTH transition pulses; saturated shifts and loads do not
      done <= is_shift && (cnt == CNT_LAST);
    end else begin
      done <= 1'b0;
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at WIDTH=8, RESET_VAL=0.
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       reset, en, sin_r, sin_l;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] q;
  logic       sout_l, sout_r, done;
  logic [3:0] cnt;

  int passed = 0;
  int total  = 0;

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_l(sout_l), .sout_r(sout_r),
    .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] m, input logic [7:0] dv);
    en = 1'b1; mode = m; d = dv;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; mode = 3'b110; d = 8'hFF; sin_r = 1'b0; sin_l = 1'b0;
    step();
    total++; if (q !== 8'h00) $display("FAIL reset_q q=%h exp=00", q); else passed++;
    total++; if (cnt !== 4'd0) $display("FAIL reset_cnt cnt=%0d exp=0", cnt); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done done=%b exp=0", done); else passed++;
    total++; if ({sout_l, sout_r} !== 2'b00) $display("FAIL reset_sout got=%b exp=00", {sout_l, sout_r}); else passed++;
    reset = 1'b0;
    do_op(3'b110, 8'hA5);
    total++; if (q !== 8'hA5) $display("FAIL load_q q=%h exp=a5", q); else passed++;
    total++; if (cnt !== 4'd0) $display("FAIL load_cnt cnt=%0d exp=0", cnt); else passed++;
  endtask

  task automatic test_shift();
    sin_r = 1'b0;
    do_op(3'b001, 8'h00);
    total++; if (q !== 8'h4A) $display("FAIL shl_q q=%h exp=4a", q); else passed++;
    total++; if (sout_l !== 1'b0) $display("FAIL shl_sout_l got=%b exp=0", sout_l); else passed++;
    total++; if (cnt !== 4'd1) $display("FAIL shl_cnt cnt=%0d exp=1", cnt); else passed++;
    do_op(3'b110, 8'h85);
    do_op(3'b011, 8'h00);
    total++; if (q !== 8'hC2) $display("FAIL asr_q q=%h exp=c2", q); else passed++;
    do_op(3'b110, 8'h85);
    sin_l = 1'b0;
    do_op(3'b010, 8'h00);
    total++; if (q !== 8'h42) $display("FAIL shr_q q=%h exp=42", q); else passed++;
    do_op(3'b110, 8'h85);
    sin_r = 1'b1;
    do_op(3'b001, 8'h00);
    total++; if (q !== 8'h0B) $display("FAIL shl_sin1_q q=%h exp=0b", q); else passed++;
    sin_r = 1'b0;
  endtask

  task automatic test_rotate();
    do_op(3'b110, 8'h01);
    do_op(3'b101, 8'h00);
    total++; if (q !== 8'h80) $display("FAIL ror_q q=%h exp=80", q); else passed++;
    total++; if (cnt !== 4'd1) $display("FAIL ror_cnt cnt=%0d exp=1", cnt); else passed++;
    total++; if (sout_l !== 1'b1 || sout_r !== 1'b0) $display("FAIL ror_sout got=%b%b exp=10", sout_l, sout_r); else passed++;
    do_op(3'b100, 8'h00);
    total++; if (q !== 8'h01) $display("FAIL rol_q q=%h exp=01", q); else passed++;
    total++; if (cnt !== 4'd2) $display("FAIL rol_cnt cnt=%0d exp=2", cnt); else passed++;
  endtask

  task automatic test_serial();
    logic [7:0] bits;
    bits = 8'hA5;
    sin_r = 1'b0;
    do_op(3'b110, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      total++; if (sout_l !== bits[7-i]) $display("FAIL ser_sout_l[%0d] got=%b exp=%b", i, sout_l, bits[7-i]); else passed++;
      do_op(3'b001, 8'h00);
      if (i < 7) begin
        total++; if (done !== 1'b0) $display("FAIL ser_done_early[%0d] done=%b exp=0", i, done); else passed++;
      end
    end
    total++; if (q !== 8'h00) $display("FAIL ser_q q=%h exp=00", q); else passed++;
    total++; if (cnt !== 4'd8) $display("FAIL ser_cnt cnt=%0d exp=8", cnt); else passed++;
    total++; if (done !== 1'b1) $display("FAIL ser_done done=%b exp=1", done); else passed++;
    do_op(3'b001, 8'h00);
    total++; if (cnt !== 4'd8) $display("FAIL ser_sat_cnt cnt=%0d exp=8", cnt); else passed++;
    total++; if (done !== 1'b0) $display("FAIL ser_sat_done done=%b exp=0", done); else passed++;
  endtask

  task automatic test_enable();
    sin_r = 1'b0;
    do_op(3'b110, 8'hA5);
    for (int i = 0; i < 3; i++) do_op(3'b001, 8'h00);
    en = 1'b0; mode = 3'b001;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (q !== 8'h28 || cnt !== 4'd3 || done !== 1'b0)
        $display("FAIL en0_hold[%0d] q=%h cnt=%0d done=%b exp=28/3/0", i, q, cnt, done); else passed++;
    end
    do_op(3'b111, 8'hFF);
    total++; if (q !== 8'h28 || cnt !== 4'd3) $display("FAIL rsvd_hold q=%h cnt=%0d exp=28/3", q, cnt); else passed++;
    do_op(3'b000, 8'hFF);
    total++; if (q !== 8'h28 || cnt !== 4'd3) $display("FAIL mode0_hold q=%h cnt=%0d exp=28/3", q, cnt); else passed++;
    for (int i = 0; i < 4; i++) do_op(3'b001, 8'h00);
    total++; if (q !== 8'h80 || cnt !== 4'd7) $display("FAIL en_cnt7 q=%h cnt=%0d exp=80/7", q, cnt); else passed++;
    en = 1'b0; mode = 3'b001;
    step();
    total++; if (done !== 1'b0 || cnt !== 4'd7) $display("FAIL en0_at7 done=%b cnt=%0d exp=0/7", done, cnt); else passed++;
    do_op(3'b001, 8'h00);
    total++; if (done !== 1'b1 || cnt !== 4'd8 || q !== 8'h00) $display("FAIL en_done q=%h cnt=%0d done=%b exp=00/8/1", q, cnt, done); else passed++;
    en = 1'b0;
    step();
    total++; if (done !== 1'b0 || cnt !== 4'd8) $display("FAIL en0_done_clr done=%b cnt=%0d exp=0/8", done, cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    sin_r = 1'b0;
    do_op(3'b110, 8'hA5);
    for (int i = 0; i < 5; i++) do_op(3'b001, 8'h00);
    total++; if (cnt !== 4'd5) $display("FAIL mid_cnt5 cnt=%0d exp=5", cnt); else passed++;
    reset = 1'b1; en = 1'b1; mode = 3'b001;
    step();
    reset = 1'b0;
    total++; if (q !== 8'h00 || cnt !== 4'd0 || done !== 1'b0) $display("FAIL mid_reset q=%h cnt=%0d done=%b exp=00/0/0", q, cnt, done); else passed++;
    do_op(3'b000, 8'h00);
    total++; if (done !== 1'b0) $display("FAIL mid_reset_nodone done=%b exp=0", done); else passed++;
  endtask

  task automatic test_load_priority();
    sin_r = 1'b0;
    do_op(3'b110, 8'hA5);
    for (int i = 0; i < 7; i++) do_op(3'b001, 8'h00);
    total++; if (cnt !== 4'd7) $display("FAIL lp_cnt7 cnt=%0d exp=7", cnt); else passed++;
    do_op(3'b110, 8'h3C);
    total++; if (q !== 8'h3C || cnt !== 4'd0 || done !== 1'b0) $display("FAIL lp_load q=%h cnt=%0d done=%b exp=3c/0/0", q, cnt, done); else passed++;
    do_op(3'b000, 8'h00);
    total++; if (done !== 1'b0) $display("FAIL lp_nodone done=%b exp=0", done); else passed++;
  endtask

  task automatic test_back_to_back();
    do_op(3'b110, 8'h81);
    sin_r = 1'b1;
    do_op(3'b001, 8'h00);
    total++; if (q !== 8'h03 || cnt !== 4'd1) $display("FAIL b2b_shl q=%h cnt=%0d exp=03/1", q, cnt); else passed++;
    do_op(3'b101, 8'h00);
    total++; if (q !== 8'h81 || cnt !== 4'd2) $display("FAIL b2b_ror q=%h cnt=%0d exp=81/2", q, cnt); else passed++;
    do_op(3'b011, 8'h00);
    total++; if (q !== 8'hC0 || cnt !== 4'd3) $display("FAIL b2b_asr q=%h cnt=%0d exp=c0/3", q, cnt); else passed++;
    do_op(3'b110, 8'h12);
    total++; if (q !== 8'h12 || cnt !== 4'd0) $display("FAIL b2b_load q=%h cnt=%0d exp=12/0", q, cnt); else passed++;
    sin_l = 1'b1;
    do_op(3'b010, 8'h00);
    total++; if (q !== 8'h89 || cnt !== 4'd1) $display("FAIL b2b_shr q=%h cnt=%0d exp=89/1", q, cnt); else passed++;
    total++; if (sout_r !== 1'b1) $display("FAIL b2b_sout_r got=%b exp=1", sout_r); else passed++;
    sin_l = 1'b0; sin_r = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
    #2;
    test_reset();
    test_shift();
    test_rotate();
    test_serial();
    test_enable();
    test_reset_mid();
    test_load_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
